// File: rtl/sequence_pattern_detector_param.sv
// sequence_pattern_detector_param
// Serial bit-pattern detector with a runtime-loadable pattern of 1..PAT_W
// bits, overlapping / non-overlapping match modes, an input-valid qualifier
// and a saturating match counter. A completed pattern raises `out` for one
// cycle, registered on the edge that sampled the final pattern bit.
//
// Handshake: `in` is consumed only on a rising edge where in_valid=1 and
// pat_load=0. There is no back-pressure; the block is always ready.
//
// The state is not stored separately. It is derived from len and fill:
//   IDLE  (len==0)    : never matches, fill held at 0
//   FILL  (fill<len)  : collecting bits
//   ARMED (fill>=len) : every further valid bit can complete a match
module sequence_pattern_detector_param #(
  parameter int                PAT_W   = 8,
  parameter int                LEN_W   = 4,
  parameter int                CNT_W   = 8,
  parameter logic [PAT_W-1:0]  RST_PAT = 8'b0011_0101,
  parameter int                RST_LEN = 6
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_value,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat, pat_n;
  logic [LEN_W-1:0] len, len_n;
  logic [PAT_W-1:0] hist, hist_n;
  logic [LEN_W-1:0] fill, fill_n;
  logic             out_n;
  logic [CNT_W-1:0] cnt_n;

  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill_inc;
  logic             match;
  state_t           state;

  // Register bank: pattern, length, history, fill level, pulse and counter.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      pat       <= RST_PAT;
      len       <= RST_LEN_L;
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else begin
      pat       <= pat_n;
      len       <= len_n;
      hist      <= hist_n;
      fill      <= fill_n;
      out       <= out_n;
      match_cnt <= cnt_n;
    end
  end

  // Match evaluation on the post-shift history, restricted to the low len bits.
  always_comb begin
    hist_shift = (hist << 1) | {{(PAT_W-1){1'b0}}, in};
    fill_inc   = (fill >= PAT_W_L) ? PAT_W_L : fill + 1'b1;
    len_mask   = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len));
    end
    match = in_valid && !pat_load && (len != '0) && (fill_inc >= len) &&
            ((hist_shift & len_mask) == (pat & len_mask));
  end

  // Next-state logic; a load takes priority over a valid bit and drops it.
  always_comb begin
    pat_n  = pat;
    len_n  = len;
    hist_n = hist;
    fill_n = fill;
    out_n  = 1'b0;
    cnt_n  = match_cnt;
    if (pat_load) begin
      pat_n  = pat_value;
      len_n  = (pat_len > PAT_W_L) ? PAT_W_L : pat_len;
      fill_n = '0;
    end else if (in_valid) begin
      hist_n = hist_shift;
      fill_n = (len == '0) ? '0 : fill_inc;
      if (match) begin
        out_n = 1'b1;
        if (!overlap) begin
          fill_n = '0;
        end
      end
    end
    // Clear beats a same-edge match; the pulse on `out` is still produced.
    if (cnt_clr) begin
      cnt_n = '0;
    end else if (match && (match_cnt != CNT_MAX)) begin
      cnt_n = match_cnt + 1'b1;
    end
  end

  // Derived state for the armed flag and the debug view.
  always_comb begin
    state = ST_FILL;
    if (len == '0) begin
      state = ST_IDLE;
    end else if (fill >= len) begin
      state = ST_ARMED;
    end
    armed     = (state == ST_ARMED);
    state_dbg = state;
  end

endmodule

// File: tb/tb_sequence_pattern_detector_param.sv
// Directed bench for sequence_pattern_detector_param. A default-width
// instance and a CNT_W=2 instance share all inputs; the narrow one is only
// examined for counter saturation.
module tb_sequence_pattern_detector_param;

  logic       clk;
  logic       rest;
  logic       in_valid;
  logic       in;
  logic       overlap;
  logic       pat_load;
  logic [7:0] pat_value;
  logic [3:0] pat_len;
  logic       cnt_clr;

  logic       out, armed;
  logic [7:0] match_cnt;
  logic [1:0] state_dbg;
  logic       out2, armed2;
  logic [1:0] match_cnt2;
  logic [1:0] state_dbg2;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;

  sequence_pattern_detector_param dut (
    .clk(clk), .rest(rest), .in_valid(in_valid), .in(in), .overlap(overlap),
    .pat_load(pat_load), .pat_value(pat_value), .pat_len(pat_len),
    .cnt_clr(cnt_clr), .out(out), .match_cnt(match_cnt), .armed(armed),
    .state_dbg(state_dbg)
  );

  sequence_pattern_detector_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rest(rest), .in_valid(in_valid), .in(in), .overlap(overlap),
    .pat_load(pat_load), .pat_value(pat_value), .pat_len(pat_len),
    .cnt_clr(cnt_clr), .out(out2), .match_cnt(match_cnt2), .armed(armed2),
    .state_dbg(state_dbg2)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic bit_in(input logic b);
    in_valid = 1'b1;
    in       = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in       = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v, input logic [3:0] l, input logic clr);
    pat_load  = 1'b1;
    pat_value = v;
    pat_len   = l;
    cnt_clr   = clr;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  initial begin
    rest = 1'b1; in_valid = 1'b0; in = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_value = '0; pat_len = '0; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(S_FILL));
    rest = 1'b0;
    idle();

    // Default pattern 110101, overlapping
    bit_in(1); chk("t1_b1_out", 32'(out), 32'd0); chk("t1_b1_arm", 32'(armed), 32'd0);
    bit_in(1); chk("t1_b2_out", 32'(out), 32'd0);
    bit_in(0); chk("t1_b3_out", 32'(out), 32'd0);
    bit_in(1); chk("t1_b4_out", 32'(out), 32'd0);
    bit_in(0); chk("t1_b5_out", 32'(out), 32'd0); chk("t1_b5_arm", 32'(armed), 32'd0);
    bit_in(1); chk("t1_b6_out", 32'(out), 32'd1); chk("t1_b6_arm", 32'(armed), 32'd1);
    chk("t1_cnt", 32'(match_cnt), 32'd1);
    idle(); chk("t1_idle_out", 32'(out), 32'd0); chk("t1_idle_arm", 32'(armed), 32'd1);

    // Pattern 101, overlapping
    load(8'b101, 4'd3, 1'b1);
    chk("t2_ld_out", 32'(out), 32'd0); chk("t2_ld_cnt", 32'(match_cnt), 32'd0);
    chk("t2_ld_arm", 32'(armed), 32'd0);
    bit_in(1); chk("t2_b1", 32'(out), 32'd0);
    bit_in(0); chk("t2_b2", 32'(out), 32'd0);
    bit_in(1); chk("t2_b3", 32'(out), 32'd1);
    bit_in(0); chk("t2_b4", 32'(out), 32'd0);
    bit_in(1); chk("t2_b5", 32'(out), 32'd1);
    chk("t2_cnt", 32'(match_cnt), 32'd2);

    // Pattern 101 via upper-bit junk 8'hFD, non-overlapping
    overlap = 1'b0;
    load(8'hFD, 4'd3, 1'b1);
    bit_in(1); chk("t2n_b1", 32'(out), 32'd0);
    bit_in(0); chk("t2n_b2", 32'(out), 32'd0);
    bit_in(1); chk("t2n_b3", 32'(out), 32'd1);
    bit_in(0); chk("t2n_b4", 32'(out), 32'd0);
    bit_in(1); chk("t2n_b5", 32'(out), 32'd0);
    chk("t2n_cnt", 32'(match_cnt), 32'd1);

    // Pattern 110101 with idle gaps between the first three bits
    load(8'b0011_0101, 4'd6, 1'b1);
    bit_in(1); chk("t3_b1", 32'(out), 32'd0);
    idle(); chk("t3_g1a", 32'(out), 32'd0);
    idle(); chk("t3_g1b", 32'(out), 32'd0);
    bit_in(1); chk("t3_b2", 32'(out), 32'd0);
    idle(); chk("t3_g2a", 32'(out), 32'd0);
    idle(); chk("t3_g2b", 32'(out), 32'd0);
    bit_in(0); chk("t3_b3", 32'(out), 32'd0);
    bit_in(1); chk("t3_b4", 32'(out), 32'd0);
    bit_in(0); chk("t3_b5", 32'(out), 32'd0);
    bit_in(1); chk("t3_b6", 32'(out), 32'd1);
    chk("t3_cnt", 32'(match_cnt), 32'd1);

    // Pattern "1", counter saturation on the 2-bit instance
    load(8'h01, 4'd1, 1'b1);
    bit_in(1); chk("t4_o1", 32'(out), 32'd1); chk("t4_c1", 32'(match_cnt2), 32'd1);
    bit_in(1); chk("t4_o2", 32'(out), 32'd1); chk("t4_c2", 32'(match_cnt2), 32'd2);
    bit_in(1); chk("t4_o3", 32'(out), 32'd1); chk("t4_c3", 32'(match_cnt2), 32'd3);
    bit_in(1); chk("t4_o4", 32'(out), 32'd1); chk("t4_c4", 32'(match_cnt2), 32'd3);
    bit_in(1); chk("t4_o5", 32'(out), 32'd1); chk("t4_c5", 32'(match_cnt2), 32'd3);
    chk("t4_wide_cnt", 32'(match_cnt), 32'd5);
    cnt_clr = 1'b1;
    bit_in(1); cnt_clr = 1'b0;
    chk("t4_clr_out", 32'(out), 32'd1); chk("t4_clr_c2", 32'(match_cnt2), 32'd0);
    chk("t4_clr_cnt", 32'(match_cnt), 32'd0);
    bit_in(1); chk("t4_o7", 32'(out), 32'd1); chk("t4_c7", 32'(match_cnt), 32'd1);

    // Asynchronous reset while out is high
    rest = 1'b1;
    #1;
    chk("t5_async_out", 32'(out), 32'd0);
    chk("t5_async_cnt", 32'(match_cnt), 32'd0);
    @(posedge clk);
    #1;
    rest = 1'b0;
    overlap = 1'b1;
    bit_in(1); bit_in(1); bit_in(0); bit_in(1);
    chk("t5_pre_out", 32'(out), 32'd0);
    rest = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rst_out", 32'(out), 32'd0); chk("t5_rst_arm", 32'(armed), 32'd0);
    rest = 1'b0;
    bit_in(0); chk("t5_b1", 32'(out), 32'd0);
    bit_in(1); chk("t5_b2", 32'(out), 32'd0);
    chk("t5_cnt", 32'(match_cnt), 32'd0);

    // Reload mid-stream discards history and the load-edge bit
    load(8'h0F, 4'd4, 1'b0);
    bit_in(1); bit_in(1); bit_in(1);
    chk("t6_pre_out", 32'(out), 32'd0);
    in_valid = 1'b1; in = 1'b1;
    load(8'h0F, 4'd4, 1'b0);
    in_valid = 1'b0;
    chk("t6_ld_out", 32'(out), 32'd0); chk("t6_ld_state", 32'(state_dbg), 32'(S_FILL));
    bit_in(1); chk("t6_b1", 32'(out), 32'd0);
    bit_in(1); chk("t6_b2", 32'(out), 32'd0);
    bit_in(1); chk("t6_b3", 32'(out), 32'd0);
    bit_in(1); chk("t6_b4", 32'(out), 32'd1);
    chk("t6_cnt", 32'(match_cnt), 32'd1);

    // Zero length: idle, never matches
    load(8'h01, 4'd0, 1'b0);
    chk("t6_idle_state", 32'(state_dbg), 32'(S_IDLE));
    bit_in(1); chk("t6_z1", 32'(out), 32'd0);
    bit_in(1); chk("t6_z2", 32'(out), 32'd0);
    bit_in(0); chk("t6_z3", 32'(out), 32'd0);
    chk("t6_z_state", 32'(state_dbg), 32'(S_IDLE));
    chk("t6_z_arm", 32'(armed), 32'd0);

    // Length 12 clamps to 8
    load(8'hFF, 4'd12, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bit_in(1);
      chk("t6_clamp_pre", 32'(out), 32'd0);
    end
    bit_in(1); chk("t6_clamp_out", 32'(out), 32'd1);
    chk("t6_clamp_arm", 32'(armed), 32'd1);
    chk("t6_clamp_cnt", 32'(match_cnt), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
